// File: rtl/calc_display_pkg.sv
// calc_display_pkg: shared types and constants for the 7-segment display
// driver and its sequential binary-to-BCD converter.
package calc_display_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;

    localparam int         N_DIGITS  = 8;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns, indexed by hex digit value.
    // Entry 15 is written first because this is a packed concatenation.
    localparam logic [15:0][6:0] SEG_CODES = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, 16-bit binary to
// 5 BCD digits. It starts a conversion whenever the input differs from the
// last converted word. The result register changes only when a conversion
// completes, so it never shows a partial result.
//   clk    - system clock
//   reset  - asynchronous, active-high
//   bin    - binary word to convert
//   bcd    - last completed result (5 nibbles, nibble 0 = units)
module bin2bcd_seq
    import calc_display_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] bin,
    output logic [19:0] bcd
);

    conv_state_t state;
    logic [15:0] bin_sh;
    logic [15:0] last_value;
    logic [15:0] cap;
    logic [19:0] acc;
    logic [19:0] adj;
    logic [3:0]  cnt;

    // Before each shift, add 3 to every nibble >= 5.
    always_comb begin
        adj = acc;
        for (int i = 0; i < 5; i++) begin
            if (acc[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bin_sh     <= '0;
            last_value <= '0;
            cap        <= '0;
            acc        <= '0;
            cnt        <= '0;
            bcd        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Inputs seen while busy are picked up here, so the
                    // final word is always converted.
                    if (bin != last_value) begin
                        bin_sh <= bin;
                        cap    <= bin;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    {acc, bin_sh} <= {adj, bin_sh} << 1;
                    cnt           <= cnt + 4'd1;
                    if (cnt == 4'd15)
                        state <= DONE;
                end
                DONE: begin
                    bcd        <= acc;
                    last_value <= cap;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/calc_display_driver.sv
// calc_display_driver: drives an 8-digit multiplexed 7-segment display
// with a 16-bit word, shown as 4 hex digits or 5 unsigned decimal digits,
// with leading zeros blanked.
//   clk      - system clock
//   reset    - asynchronous, active-high
//   value    - word to display
//   dec_mode - 1 = unsigned decimal, 0 = hex
//   an_n     - active-low digit anodes, digit 0 rightmost
//   seg_n    - active-low segments {g,f,e,d,c,b,a}
module calc_display_driver
    import calc_display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic        dec_mode,
    output logic [7:0]  an_n,
    output logic [6:0]  seg_n
);

    localparam int DW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic [DW-1:0]              div_cnt;
    logic [2:0]                 idx;
    logic [19:0]                bcd_reg;
    logic [N_DIGITS-1:0][3:0]   digit;
    logic [N_DIGITS-1:0]        lit;
    logic                       any_nz;
    int                         n_rng;
    logic                       wrap;

    bin2bcd_seq u_conv (
        .clk   (clk),
        .reset (reset),
        .bin   (value),
        .bcd   (bcd_reg)
    );

    // Digit mux and leading-zero blanking. Walking from the top digit down,
    // a digit is lit once any in-range digit at or above it is nonzero;
    // digit 0 is always lit so zero shows as "0".
    always_comb begin
        digit = '0;
        if (dec_mode) begin
            digit[4:0] = bcd_reg;
            n_rng      = 5;
        end else begin
            digit[3:0] = value;
            n_rng      = 4;
        end
        any_nz = 1'b0;
        lit    = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            if (i < n_rng) begin
                any_nz = any_nz | (digit[i] != 4'd0);
                lit[i] = any_nz | (i == 0);
            end
        end
    end

    assign wrap = (div_cnt == DW'(REFRESH_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            idx     <= '0;
            an_n    <= 8'hFF;
            seg_n   <= SEG_BLANK;
        end else if (wrap) begin
            div_cnt <= '0;
            idx     <= idx + 3'd1;
            if (lit[idx]) begin
                an_n  <= ~(8'h01 << idx);
                seg_n <= SEG_CODES[digit[idx]];
            end else begin
                an_n  <= 8'hFF;
                seg_n <= SEG_BLANK;
            end
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

endmodule

// File: tb/tb_calc_display_driver.sv
// tb_calc_display_driver: scoreboard bench. Each displayed word pushes the
// eight expected slot patterns of one frame; a monitor pops and compares one
// entry per scan slot. Converter latency, mid-conversion changes and reset
// behaviour are checked directly.
module tb_calc_display_driver;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] value = '0;
    logic        dec_mode = 1'b0;
    logic [7:0]  an_n;
    logic [6:0]  seg_n;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int mon_slot = 0;
    logic [14:0] sb[$];

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    calc_display_driver #(.REFRESH_DIV(DIV)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .value    (value),
        .dec_mode (dec_mode),
        .an_n     (an_n),
        .seg_n    (seg_n)
    );

    always #5 clk = ~clk;

    // Cycles since reset release; a scan slot is loaded when this is a
    // nonzero multiple of DIV.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [19:0] to_bcd(input logic [15:0] v);
        logic [19:0] r;
        int x;
        r = '0;
        x = v;
        for (int k = 0; k < 5; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [14:0] exp_slot(input int s, input logic [15:0] v, input bit dec);
        int d[8];
        int rng;
        int ndig;
        int x;
        logic [7:0] one;
        for (int k = 0; k < 8; k++) d[k] = 0;
        x = v;
        if (dec) begin
            rng = 5;
            for (int k = 0; k < 5; k++) begin
                d[k] = x % 10;
                x = x / 10;
            end
        end else begin
            rng = 4;
            for (int k = 0; k < 4; k++) d[k] = (x >> (4*k)) & 15;
        end
        ndig = 1;
        for (int k = 0; k < rng; k++) if (d[k] != 0) ndig = k + 1;
        one = 8'h01;
        if (s < ndig) return {~(one << s), seg_tab[d[s]]};
        return {8'hFF, 7'h7F};
    endfunction

    // Monitor: one comparison per loaded slot while the scoreboard holds
    // expectations.
    always @(negedge clk) begin
        if (!reset && cyc != 0 && (cyc % DIV) == 0 && sb.size() > 0) begin
            logic [14:0] e;
            e = sb.pop_front();
            chk($sformatf("slot%0d", mon_slot), {17'b0, an_n, seg_n}, {17'b0, e});
            mon_slot = (mon_slot + 1) % 8;
        end
    end

    // Apply a word, let the converter settle, then expect one whole frame
    // starting at slot 0.
    task automatic show(input logic [15:0] v, input bit dec);
        int n;
        value    = v;
        dec_mode = dec;
        repeat (40) @(negedge clk);
        n = 0;
        while (!(cyc != 0 && (cyc % (8*DIV)) == 0) && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("frame_align", (n < 64) ? 32'd1 : 32'd0, 32'd1);
        #1;
        mon_slot = 0;
        for (int s = 0; s < 8; s++) sb.push_back(exp_slot(s, v, dec));
        n = 0;
        while (sb.size() > 0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk("frame_drain", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        bit seen;
        bit bad;
        logic [19:0] b;

        // Reset and first lit slot.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_an", an_n, 8'hFF);
        chk("rst_seg", seg_n, 7'h7F);
        reset = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            @(negedge clk);
            chk($sformatf("pre_an%0d", e), an_n, 8'hFF);
            chk($sformatf("pre_seg%0d", e), seg_n, 7'h7F);
        end
        @(negedge clk);
        chk("first_an", an_n, 8'hFE);
        chk("first_seg", seg_n, 7'h40);

        // Hex frame.
        show(16'hBEEF, 1'b0);

        // Converter latency: sampled on the next edge, result 17 edges later.
        value    = 16'd65535;
        dec_mode = 1'b1;
        repeat (17) @(posedge clk);
        #1 chk("lat_old", u_dut.bcd_reg, to_bcd(16'hBEEF));
        @(posedge clk);
        #1 chk("lat_new", u_dut.bcd_reg, 20'h65535);

        show(16'd65535, 1'b1);
        show(16'h00A0, 1'b0);
        show(16'h0000, 1'b0);
        show(16'h0000, 1'b1);

        // Change during conversion: only complete results ever appear.
        seen = 0;
        bad  = 0;
        @(negedge clk);
        value = 16'd1234;
        for (int c = 0; c < 80; c++) begin
            if (c == 5) value = 16'd9;
            @(negedge clk);
            b = u_dut.bcd_reg;
            if (b == 20'h01234) seen = 1;
            else if (b == 20'h00009) begin
                if (!seen) bad = 1;
            end else if (b != 20'h0) bad = 1;
        end
        chk("mid_seen1234", {31'b0, seen}, 32'd1);
        chk("mid_nopartial", {31'b0, bad}, 32'd0);
        chk("mid_final", u_dut.bcd_reg, 20'h00009);
        show(16'd9, 1'b1);

        // Reset during conversion.
        @(negedge clk);
        value = 16'd4321;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rmid_an", an_n, 8'hFF);
        chk("rmid_seg", seg_n, 7'h7F);
        chk("rmid_bcd", u_dut.bcd_reg, 20'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("rmid_reconv", u_dut.bcd_reg, to_bcd(16'd4321));
        show(16'd4321, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
